// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding definitions: base opcodes, instruction classes and
// the rejection codes reported by the instruction-word encoder.
package rv_isa_pkg;

    typedef enum logic [6:0] {
        OpRType       = 7'b0110011,
        OpLoad        = 7'b0000011,
        OpIType       = 7'b0010011,
        OpSType       = 7'b0100011,
        OpBType       = 7'b1100011,
        OpAddUpp      = 7'b0010111,
        OpLoadUpp     = 7'b0110111,
        OpJumpLink    = 7'b1101111,
        OpJumpLinkReg = 7'b1100111
    } opcode_t;

    typedef enum logic [3:0] {
        ClsRType       = 4'd0,
        ClsLoad        = 4'd1,
        ClsIType       = 4'd2,
        ClsSType       = 4'd3,
        ClsBType       = 4'd4,
        ClsAddUpp      = 4'd5,
        ClsLoadUpp     = 4'd6,
        ClsJumpLink    = 4'd7,
        ClsJumpLinkReg = 4'd8
    } instr_class_t;

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrIllegal  = 2'd1;
    localparam logic [1:0] ErrRange    = 2'd2;
    localparam logic [1:0] ErrMisalign = 2'd3;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction class plus operand fields to a 32-bit
// RV32I word, with the rejection cause (illegal > misaligned > range).
module instr_field_packer
    import rv_isa_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [1:0]  errCode
);

    logic fitsI;
    logic fitsB;
    logic fitsJ;

    // An immediate fits when every bit above the field's sign bit repeats it.
    assign fitsI = (imm[31:11] == {21{imm[11]}});
    assign fitsB = (imm[31:12] == {20{imm[12]}});
    assign fitsJ = (imm[31:20] == {12{imm[20]}});

    always_comb begin
        word    = '0;
        errCode = ErrNone;
        case (instr_class_t'(cls))
            ClsRType: begin
                word = {funct7, rs2, rs1, funct3, rd, OpRType};
            end
            ClsLoad: begin
                word = {imm[11:0], rs1, funct3, rd, OpLoad};
                if (!fitsI) errCode = ErrRange;
            end
            ClsIType: begin
                word = {imm[11:0], rs1, funct3, rd, OpIType};
                if (!fitsI) errCode = ErrRange;
            end
            ClsJumpLinkReg: begin
                word = {imm[11:0], rs1, 3'b000, rd, OpJumpLinkReg};
                if (!fitsI) errCode = ErrRange;
            end
            ClsSType: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpSType};
                if (!fitsI) errCode = ErrRange;
            end
            ClsBType: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBType};
                if (imm[0])      errCode = ErrMisalign;
                else if (!fitsB) errCode = ErrRange;
            end
            ClsAddUpp: begin
                word = {imm[31:12], rd, OpAddUpp};
            end
            ClsLoadUpp: begin
                word = {imm[31:12], rd, OpLoadUpp};
            end
            ClsJumpLink: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJumpLink};
                if (imm[0])      errCode = ErrMisalign;
                else if (!fitsJ) errCode = ErrRange;
            end
            default: begin
                errCode = ErrIllegal;
            end
        endcase
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Encodes loader requests into RV32I words tagged with consecutive byte
// addresses, buffered in a 2-entry FIFO with valid/ready on both sides.
module instr_word_encoder
    import rv_isa_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'hBFC00000)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        class_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    logic [31:0]       packedWord;
    logic [1:0]        packErr;
    logic [1:0]        count;
    logic [31:0]       headInstr;
    logic [ADDR_W-1:0] headAddr;
    logic [31:0]       tailInstr;
    logic [ADDR_W-1:0] tailAddr;
    logic [ADDR_W-1:0] nextAddr;
    logic              errPulse;
    logic [1:0]        errCodeQ;
    logic              accept;
    logic              pushOk;
    logic              pop;

    instr_field_packer uPacker (
        .cls     (class_i),
        .rd      (rd_i),
        .rs1     (rs1_i),
        .rs2     (rs2_i),
        .funct3  (funct3_i),
        .funct7  (funct7_i),
        .imm     (imm_i),
        .word    (packedWord),
        .errCode (packErr)
    );

    // Ready depends only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = (count != 2'd2);
    assign out_valid_o = (count != 2'd0);
    assign accept      = in_valid_i && in_ready_o;
    assign pushOk      = accept && (packErr == ErrNone);
    assign pop         = out_valid_o && out_ready_i;

    assign instr_o    = headInstr;
    assign addr_o     = headAddr;
    assign err_o      = errPulse;
    assign err_code_o = errCodeQ;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count     <= 2'd0;
            headInstr <= '0;
            headAddr  <= '0;
            tailInstr <= '0;
            tailAddr  <= '0;
            nextAddr  <= BASE_ADDR;
            errPulse  <= 1'b0;
            errCodeQ  <= ErrNone;
        end else if (clear_i) begin
            // The last rejection cause survives a clear for post-mortem reads.
            count     <= 2'd0;
            headInstr <= '0;
            headAddr  <= '0;
            tailInstr <= '0;
            tailAddr  <= '0;
            nextAddr  <= BASE_ADDR;
            errPulse  <= 1'b0;
        end else begin
            errPulse <= accept && (packErr != ErrNone);
            if (accept && (packErr != ErrNone)) begin
                errCodeQ <= packErr;
            end
            if (pushOk) begin
                nextAddr <= nextAddr + ADDR_W'(4);
            end
            case ({pushOk, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        headInstr <= packedWord;
                        headAddr  <= nextAddr;
                    end else begin
                        tailInstr <= packedWord;
                        tailAddr  <= nextAddr;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        headInstr <= tailInstr;
                        headAddr  <= tailAddr;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new word replaces the head.
                    headInstr <= packedWord;
                    headAddr  <= nextAddr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: vector table, hand-written
// backpressure/clear/wrap sequences and randomized traffic against a model.
module tb_instr_word_encoder;

    localparam logic [31:0] BASE = 32'hBFC00000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clear, inValid, outReady;
    logic [3:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        inReady, outValid, err;
    logic [31:0] instr, addr;
    logic [1:0]  errCode;

    logic        wClear, wValid, wReady;
    logic        wInReady, wOutValid, wErr;
    logic [31:0] wInstr, wAddr;
    logic [1:0]  wErrCode;

    instr_word_encoder dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .class_i(cls), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .instr_o(instr), .addr_o(addr), .err_o(err), .err_code_o(errCode)
    );

    instr_word_encoder #(.ADDR_W(32), .BASE_ADDR(32'hFFFFFFFC)) dutWrap (
        .clk_i(clk), .rst_i(rst), .clear_i(wClear),
        .in_valid_i(wValid), .in_ready_o(wInReady),
        .class_i(cls), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .funct3_i(f3), .funct7_i(f7), .imm_i(imm),
        .out_valid_o(wOutValid), .out_ready_i(wReady),
        .instr_o(wInstr), .addr_o(wAddr), .err_o(wErr), .err_code_o(wErrCode)
    );

    int nCmp = 0;
    int nBad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the ISA field layout with plain arithmetic.
    function automatic logic [31:0] refEnc(input int c, input logic [31:0] r, s1, s2, fn3, fn7,
                                           input logic [31:0] im, output logic [1:0] code);
        logic [31:0] w;
        int          s;
        s    = int'(im);
        w    = 0;
        code = 0;
        case (c)
            0: w = 32'h33 | (r << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20) | (fn7 << 25);
            1, 2, 8: begin
                w = ((c == 1) ? 32'h03 : (c == 2) ? 32'h13 : 32'h67) | (r << 7)
                    | (((c == 8) ? 32'd0 : fn3) << 12) | (s1 << 15) | ((im & 32'hFFF) << 20);
                if (s < -2048 || s > 2047) code = 2;
            end
            3: begin
                w = 32'h23 | ((im & 31) << 7) | (fn3 << 12) | (s1 << 15) | (s2 << 20)
                    | (((im >> 5) & 127) << 25);
                if (s < -2048 || s > 2047) code = 2;
            end
            4: begin
                w = 32'h63 | (((im >> 11) & 1) << 7) | (((im >> 1) & 15) << 8) | (fn3 << 12)
                    | (s1 << 15) | (s2 << 20) | (((im >> 5) & 63) << 25) | (((im >> 12) & 1) << 31);
                if (im[0]) code = 3;
                else if (s < -4096 || s > 4095) code = 2;
            end
            5, 6: w = ((c == 5) ? 32'h17 : 32'h37) | (r << 7) | (im & 32'hFFFFF000);
            7: begin
                w = 32'h6F | (r << 7) | (((im >> 12) & 255) << 12) | (((im >> 11) & 1) << 20)
                    | (((im >> 1) & 1023) << 21) | (((im >> 20) & 1) << 31);
                if (im[0]) code = 3;
                else if (s < -(1 << 20) || s > (1 << 20) - 1) code = 2;
            end
            default: code = 1;
        endcase
        return w;
    endfunction

    logic [31:0] qInstr[$];
    logic [31:0] qAddr[$];
    logic [31:0] mAddr;
    logic        mErr;
    logic [1:0]  mCode;
    logic        mZero;

    // Compare DUT against the model, then advance the model and the clock.
    task automatic tick();
        logic [31:0] w;
        logic [1:0]  code;
        logic        acc, pp;
        check("in_ready", 32'(inReady), 32'(qInstr.size() < 2));
        check("out_valid", 32'(outValid), 32'(qInstr.size() > 0));
        if (qInstr.size() > 0) begin
            check("instr", instr, qInstr[0]);
            check("addr", addr, qAddr[0]);
        end else if (mZero) begin
            check("instr_idle", instr, 32'h0);
            check("addr_idle", addr, 32'h0);
        end
        check("err", 32'(err), 32'(mErr));
        check("err_code", 32'(errCode), 32'(mCode));
        if (rst) begin
            qInstr.delete(); qAddr.delete();
            mAddr = BASE; mErr = 0; mCode = 0; mZero = 1;
        end else if (clear) begin
            qInstr.delete(); qAddr.delete();
            mAddr = BASE; mErr = 0; mZero = 1;
        end else begin
            acc = inValid && (qInstr.size() < 2);
            pp  = (qInstr.size() > 0) && outReady;
            if (pp) begin
                void'(qInstr.pop_front());
                void'(qAddr.pop_front());
            end
            mErr = 0;
            if (acc) begin
                w = refEnc(int'(cls), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm, code);
                if (code != 0) begin
                    mErr = 1; mCode = code;
                end else begin
                    qInstr.push_back(w); qAddr.push_back(mAddr);
                    mAddr = mAddr + 4; mZero = 0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [4:0]  d, a, b;
        logic [2:0]  fn3;
        logic [6:0]  fn7;
        logic [31:0] im;
        logic [31:0] expInstr;
        logic [1:0]  expCode;
    } vec_t;

    vec_t vecs[16];

    task automatic setFields(input vec_t v);
        cls = v.c; rd = v.d; rs1 = v.a; rs2 = v.b; f3 = v.fn3; f7 = v.fn7; imm = v.im;
    endtask

    task automatic randFields();
        int sel;
        sel = $urandom_range(0, 11);
        cls = (sel > 8) ? 4'($urandom_range(9, 15)) : 4'(sel);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: imm = 32'($signed($urandom_range(0, 8191)) - 4096);
            1: imm = $urandom & 32'hFFFFFFFE;
            2: imm = 32'($signed($urandom_range(0, 4194303)) - 2097152);
            default: imm = $urandom;
        endcase
    endtask

    initial begin
        vecs[0]  = '{4'd2,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 2'd0};
        vecs[1]  = '{4'd0,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 2'd0};
        vecs[2]  = '{4'd3,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 2'd0};
        vecs[3]  = '{4'd6,  5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 2'd0};
        vecs[4]  = '{4'd7,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,        32'h008000EF, 2'd0};
        vecs[5]  = '{4'd4,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 2'd0};
        vecs[6]  = '{4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h0,        2'd1};
        vecs[7]  = '{4'd4,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h0,        2'd3};
        vecs[8]  = '{4'd2,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h0,        2'd2};
        vecs[9]  = '{4'd8,  5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'hFFFFFFFF, 32'hFFF100E7, 2'd0};
        vecs[10] = '{4'd4,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6,        32'h00000363, 2'd0};
        vecs[11] = '{4'd7,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100001, 32'h0,        2'd3};
        vecs[12] = '{4'd9,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        32'h0,        2'd1};
        vecs[13] = '{4'd1,  5'd4, 5'd3, 5'd0, 3'd2, 7'd0, 32'hFFFFFFF8, 32'hFF81A203, 2'd0};
        vecs[14] = '{4'd5,  5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF123, 32'hFFFFF117, 2'd0};
        vecs[15] = '{4'd3,  5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF, 32'h0,        2'd2};

        rst = 1; clear = 0; inValid = 0; outReady = 1;
        wClear = 0; wValid = 0; wReady = 1;
        setFields(vecs[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        qInstr.delete(); qAddr.delete();
        mAddr = BASE; mErr = 0; mCode = 0; mZero = 1;
        rst = 0;

        // Vector table, one request at a time with the consumer always ready.
        for (int i = 0; i < 16; i++) begin
            setFields(vecs[i]);
            inValid = 1;
            tick();
            inValid = 0;
            if (vecs[i].expCode == 0) begin
                check($sformatf("vec%0d_instr", i), instr, vecs[i].expInstr);
            end else begin
                check($sformatf("vec%0d_errpulse", i), 32'(err), 32'd1);
                check($sformatf("vec%0d_code", i), 32'(errCode), 32'(vecs[i].expCode));
            end
            tick();
        end

        // Back-to-back stream: one word per cycle.
        for (int i = 1; i < 4; i++) begin
            setFields(vecs[i]);
            inValid = 1;
            tick();
        end
        inValid = 0;
        tick(); tick();

        // Backpressure: third request must stall until the consumer drains.
        outReady = 0;
        for (int i = 0; i < 3; i++) begin
            setFields(vecs[i + 1]);
            inValid = 1;
            tick();
        end
        check("bp_in_ready_low", 32'(inReady), 32'd0);
        tick(); tick();
        outReady = 1;
        for (int i = 0; i < 4; i++) tick();
        inValid = 0;
        tick(); tick();

        // Clear with two buffered words, then restart from the base address.
        outReady = 0;
        setFields(vecs[0]);
        inValid = 1;
        tick(); tick();
        inValid = 0;
        clear = 1;
        tick();
        clear = 0;
        check("clear_out_valid", 32'(outValid), 32'd0);
        outReady = 1;
        inValid = 1;
        tick();
        inValid = 0;
        check("clear_restart_addr", addr, BASE);
        tick();

        // Randomized traffic with occasional clear and one mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            randFields();
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 2) != 0);
            clear    = ($urandom_range(0, 49) == 0);
            rst      = (n == 300);
            tick();
        end
        rst = 0; clear = 0; inValid = 0; outReady = 1;
        tick(); tick();

        // Address wrap on the second instance.
        setFields(vecs[0]);
        wReady = 0;
        wValid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wValid = 0;
        check("wrap_valid0", 32'(wOutValid), 32'd1);
        check("wrap_addr0", wAddr, 32'hFFFFFFFC);
        check("wrap_instr0", wInstr, 32'h00500093);
        wReady = 1;
        @(posedge clk); #1;
        check("wrap_valid1", 32'(wOutValid), 32'd1);
        check("wrap_addr1", wAddr, 32'h00000000);
        @(posedge clk); #1;
        check("wrap_drained", 32'(wOutValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
- Inverse of the control-path opcode decoder: takes an instruction class plus operand fields and packs them into a 32-bit RV32I instruction word.
- Each word is tagged with an incrementing instruction-memory byte address.
- Sits between the on-chip program loader/self-test sequencer and instruction memory. Valid/ready on both sides, 2-entry output buffer.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- BASE_ADDR, 32'hBFC00000, first address emitted after reset/clear.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous; empties buffer, reloads address counter
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- class_i  in  4  instruction class (package enum)
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3  funct3
- funct7_i  in  7  funct7 (R-type only)
- imm_i  in  32  signed/raw immediate
- out_valid_o  out  1  word available
- out_ready_i  in  1  consumer takes word when out_valid_o && out_ready_i
- instr_o  out  32  encoded instruction
- addr_o  out  ADDR_W  byte address of instr_o
- err_o  out  1  one-cycle pulse: request rejected
- err_code_o  out  2  cause of last rejection; held until next error/reset

Behaviour:
- Reset/clear: buffer empty, out_valid_o=0, instr_o=0, addr_o=0, err_o=0, addr counter=BASE_ADDR. err_code_o=0 on reset only; clear_i leaves it. clear_i has priority over same-cycle accept/pop.
- Classes: 0 RType(0110011), 1 Load(0000011), 2 IType(0010011), 3 SType(0100011), 4 BType(1100011), 5 AddUpp(0010111), 6 LoadUpp(0110111), 7 JumpLink(1101111), 8 JumpLinkReg(1100111). Values 9-15 are illegal.
- Packing, with [6:0] = opcode:
  - R: funct7|rs2|rs1|funct3|rd.
  - I (Load, IType, JumpLinkReg): imm[11:0]|rs1|funct3|rd. funct3 is forced to 000 for JumpLinkReg.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0].
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11].
  - U: imm[31:12]|rd.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
- Rejection checks at accept. A rejected request is consumed (handshake completes), nothing is enqueued, the address does not advance, err_o=1 on the next cycle.
  - Code 1, illegal class.
  - Code 2, immediate out of range: I/S imm not a sign-extension of bit 11; B not of bit 12; J not of bit 20. U-type never range-fails; imm[11:0] ignored.
  - Code 3, misaligned: B/J with imm[0]=1.
  - Priority 1 > 3 > 2.
- Accepting a legal request: word+current address pushed into buffer; address += 4, wrapping modulo 2^ADDR_W.
- Buffer: 2 entries, FIFO order.
  - in_ready_o = (count<2), registered-equivalent, no combinational path from out_ready_i.
  - Push and pop in the same cycle are allowed when count==1.
  - Latency: accept in cycle N → out_valid_o in N+1 when the buffer was empty.
  - Sustained throughput 1 word/cycle with out_ready_i held high.
- instr_o/addr_o are stable while out_valid_o && !out_ready_i. They are don't-care-but-held when empty.
- Reset or clear mid-stream discards buffered words; no partial output.

Decomposition:
- Shared package rv_isa_pkg: opcode enum (the nine 7-bit opcodes), instr-class enum, error-code constants. The existing decoder and this block both import it.
- One combinational sub-module, instr_field_packer: class+fields → 32-bit word plus err code. The top holds the handshake, FIFO and address counter.

Test Plan:
- Reset, then IType rd=1 rs1=0 funct3=0 imm=5 → next cycle out_valid_o=1, instr_o=0x00500093, addr_o=0xBFC00000.
- Back-to-back stream, out_ready_i=1:
  - RType rd=3 rs1=1 rs2=2 → 0x002081B3 @0xBFC00000.
  - SType rs1=1 rs2=2 funct3=010 imm=8 → 0x0020A423 @…04.
  - LoadUpp rd=5 imm=0x12345000 → 0x123452B7 @…08.
  - in_ready_o stays 1 throughout.
- JumpLink rd=1 imm=8 → 0x008000EF. BType rs1=rs2=0 funct3=0 imm=-4 → 0xFE000EE3.
- Backpressure: out_ready_i=0, push 3 requests → in_ready_o falls after 2. Release → words emerge in order with consecutive addresses, and no word changes while stalled.
- Errors, each with err_o pulse, no output, and the address not advancing on the next legal word:
  - class=12 → err_code_o=1.
  - BType imm=6 … imm=3 → code 3.
  - IType imm=2048 → code 2.
- Wrap and clear:
  - BASE_ADDR=32'hFFFFFFFC: two words → addresses FFFFFFFC then 00000000.
  - clear_i with 2 buffered → out_valid_o=0 next cycle, next word @BASE_ADDR.
